// File: rtl/alpha_row_sequencer_pkg.sv
// Shared sizing, field positions and state type for the alphanumeric row sequencer.
package alpha_row_sequencer_pkg;

  localparam int CHARS_PER_LINE   = 32;
  localparam int LINES_PER_ROW    = 12;
  localparam int TEXT_ROWS        = 16;
  localparam int FIRST_GLYPH_LINE = 3;
  localparam int GLYPH_LINES      = 7;
  localparam int ADDR_W           = 9;

  localparam int COL_W  = $clog2(CHARS_PER_LINE);
  localparam int LINE_W = $clog2(LINES_PER_ROW);
  localparam int ROW_W  = $clog2(TEXT_ROWS);

  localparam logic [5:0] SPACE_CODE = 6'd32;

  localparam int VID_CODE_MSB = 5;
  localparam int VID_INV_BIT  = 6;
  localparam int VID_SG_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  // Rows outside this window must never reach the ROM, since code*7+row would spill into the next glyph.
  function automatic logic is_glyph_line(input logic [LINE_W-1:0] line);
    return (line >= LINE_W'(FIRST_GLYPH_LINE)) &&
           (line <  LINE_W'(FIRST_GLYPH_LINE + GLYPH_LINES));
  endfunction

endpackage

// File: rtl/alpha_row_sequencer_if.sv
// Video RAM fetch and character ROM bus between the sequencer (master) and memories (slave).
interface alpha_row_sequencer_if;
  import alpha_row_sequencer_pkg::*;

  logic [ADDR_W-1:0] VidAddr;
  logic [7:0]        VidData;
  logic [5:0]        RomData;
  logic [3:0]        RomRow;
  logic [7:0]        RomPixels;

  modport master (
    output VidAddr, RomData, RomRow,
    input  VidData, RomPixels
  );

  modport slave (
    input  VidAddr, RomData, RomRow,
    output VidData, RomPixels
  );

endinterface

// File: rtl/alpha_row_sequencer_shift_reg.sv
// Glyph shift register: loads one ROM row, shifts it out MSB first, applies the cell's inverse flag.
module alpha_shift_reg (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  input  logic       inv_in,
  input  logic       sg_in,
  output logic       pix,
  output logic       sg
);

  logic [7:0] shreg;
  logic       inv;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      shreg <= 8'd0;
      inv   <= 1'b0;
      sg    <= 1'b0;
    end else if (load) begin
      shreg <= din;
      inv   <= inv_in;
      sg    <= sg_in;
    end else if (shift) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign pix = shreg[7] ^ inv;

endmodule

// File: rtl/alpha_row_sequencer.sv
// Alphanumeric row sequencer: line/row counting, video RAM fetch, ROM addressing and glyph shift-out.
module alpha_row_sequencer
  import alpha_row_sequencer_pkg::*;
(
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  PixClkEn,
  input  logic                  LineStart,
  input  logic                  FieldStart,
  alpha_row_sequencer_if.master bus,
  output logic                  PixelOut,
  output logic                  SgChar,
  output logic                  Active
);

  seq_state_t        state, state_next;
  logic [2:0]        pix_cnt;
  logic [COL_W-1:0]  fetch_col;
  logic [COL_W-1:0]  disp_col;
  logic [LINE_W-1:0] line_in_row;
  logic [ROW_W-1:0]  row_cnt;
  logic [5:0]        rom_data;
  logic [3:0]        rom_row;
  logic              inv_lat, sg_lat;
  logic              shr_pix, shr_sg;

  logic running, start_line, cancel, advance;
  logic do_fetch, do_load, do_shift, end_line, last_line, last_row;

  always_comb begin
    running    = (state == LEAD) || (state == ACTIVE);
    start_line = LineStart && (FieldStart || (state != HOLD));
    cancel     = FieldStart || start_line;
    advance    = running && PixClkEn && !cancel;
    do_fetch   = advance && (pix_cnt == 3'd6);
    do_load    = advance && (pix_cnt == 3'd7);
    do_shift   = advance && (state == ACTIVE) && (pix_cnt != 3'd7);
    end_line   = do_load && (state == ACTIVE) &&
                 (disp_col == COL_W'(CHARS_PER_LINE - 1));
    last_line  = (line_in_row == LINE_W'(LINES_PER_ROW - 1));
    last_row   = (row_cnt == ROW_W'(TEXT_ROWS - 1));
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  // FieldStart+LineStart together restart line 0 directly, so start_line is checked first.
  always_comb begin
    state_next = state;
    if (start_line) begin
      state_next = LEAD;
    end else if (FieldStart) begin
      state_next = IDLE;
    end else begin
      case (state)
        LEAD:    if (do_load) state_next = ACTIVE;
        ACTIVE:  if (end_line) state_next = (last_line && last_row) ? HOLD : IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pix_cnt     <= 3'd0;
      fetch_col   <= '0;
      disp_col    <= '0;
      line_in_row <= '0;
      row_cnt     <= '0;
    end else begin
      if (FieldStart) begin
        line_in_row <= '0;
        row_cnt     <= '0;
      end else if (end_line) begin
        line_in_row <= last_line ? '0 : line_in_row + LINE_W'(1);
        if (last_line) row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end

      if (start_line) begin
        pix_cnt   <= 3'd0;
        fetch_col <= '0;
        disp_col  <= '0;
      end else if (advance) begin
        pix_cnt <= pix_cnt + 3'd1;
        if (do_fetch && (fetch_col != COL_W'(CHARS_PER_LINE - 1)))
          fetch_col <= fetch_col + COL_W'(1);
        if (do_load && (state == ACTIVE))
          disp_col <= disp_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rom_data <= 6'd0;
      rom_row  <= 4'd0;
      inv_lat  <= 1'b0;
      sg_lat   <= 1'b0;
    end else if (do_fetch) begin
      if (is_glyph_line(line_in_row) && !bus.VidData[VID_SG_BIT]) begin
        rom_data <= bus.VidData[VID_CODE_MSB:0];
        rom_row  <= 4'(line_in_row - LINE_W'(FIRST_GLYPH_LINE));
      end else begin
        rom_data <= SPACE_CODE;
        rom_row  <= 4'd0;
      end
      inv_lat <= bus.VidData[VID_INV_BIT] & ~bus.VidData[VID_SG_BIT];
      sg_lat  <= bus.VidData[VID_SG_BIT];
    end
  end

  alpha_shift_reg u_shift (
    .Clk    (Clk),
    .nReset (nReset),
    .load   (do_load),
    .shift  (do_shift),
    .din    (bus.RomPixels),
    .inv_in (inv_lat),
    .sg_in  (sg_lat),
    .pix    (shr_pix),
    .sg     (shr_sg)
  );

  assign bus.VidAddr = ADDR_W'(row_cnt) * ADDR_W'(CHARS_PER_LINE) + ADDR_W'(fetch_col);
  assign bus.RomData = rom_data;
  assign bus.RomRow  = rom_row;

  assign Active   = (state == ACTIVE);
  assign PixelOut = Active & shr_pix;
  assign SgChar   = Active & shr_sg;

endmodule

// File: tb/tb_alpha_row_sequencer.sv
// Directed bench for alpha_row_sequencer with a video RAM array and a tiny character ROM model.
module tb_alpha_row_sequencer;
  import alpha_row_sequencer_pkg::*;

  logic Clk = 1'b0;
  logic nReset = 1'b1;
  logic PixClkEn = 1'b1;
  logic LineStart = 1'b0;
  logic FieldStart = 1'b0;
  logic PixelOut, SgChar, Active;

  logic [7:0] vram [0:511];
  int checks = 0;
  int errors = 0;

  alpha_row_sequencer_if bus();

  always #5 Clk = ~Clk;

  // ROM stand-in: space is blank, 'A' row 0 is a single centre dot, any other entry is solid.
  function automatic logic [7:0] rom_model(input logic [5:0] code, input logic [3:0] row);
    if (code == 6'd32) return 8'h00;
    if (code == 6'd1 && row == 4'd0) return 8'h08;
    return 8'hFF;
  endfunction

  assign bus.VidData   = vram[bus.VidAddr];
  assign bus.RomPixels = rom_model(bus.RomData, bus.RomRow);

  alpha_row_sequencer dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .PixClkEn   (PixClkEn),
    .LineStart  (LineStart),
    .FieldStart (FieldStart),
    .bus        (bus),
    .PixelOut   (PixelOut),
    .SgChar     (SgChar),
    .Active     (Active)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    LineStart = 1'b1;
    tick();
    LineStart = 1'b0;
  endtask

  // Runs one full line; optionally checks the first cell's ROM access and its eight pixels.
  task automatic runLine(input int base, input bit chk, input logic [7:0] exp_pix,
                         input logic exp_sg, input logic [5:0] exp_code, input logic [3:0] exp_row);
    int cnt;
    int maxa;
    applyStimulus();
    checkOutput("vaddr start", 32'(bus.VidAddr), base);
    cnt = 0;
    maxa = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (Active) begin
        if (int'(bus.VidAddr) > maxa) maxa = int'(bus.VidAddr);
        if (chk && cnt == 0) begin
          checkOutput("rom code", 32'(bus.RomData), 32'(exp_code));
          checkOutput("rom row", 32'(bus.RomRow), 32'(exp_row));
        end
        if (chk && cnt < 8) begin
          checkOutput("pixel", 32'(PixelOut), 32'(exp_pix[7-cnt]));
          checkOutput("sgchar", 32'(SgChar), 32'(exp_sg));
        end
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    checkOutput("active len", cnt, 256);
    checkOutput("vaddr last", maxa, base + 31);
  endtask

  initial begin
    logic [7:0] pat;
    int cnt;
    for (int a = 0; a < 512; a++) vram[a] = 8'h01;

    #2 nReset = 1'b0;
    #1;
    checkOutput("rst active", 32'(Active), 0);
    checkOutput("rst pixel", 32'(PixelOut), 0);
    checkOutput("rst sg", 32'(SgChar), 0);
    checkOutput("rst romdata", 32'(bus.RomData), 0);
    checkOutput("rst romrow", 32'(bus.RomRow), 0);
    checkOutput("rst vaddr", 32'(bus.VidAddr), 0);
    tick();
    tick();
    nReset = 1'b1;
    tick();
    FieldStart = 1'b1;
    tick();
    FieldStart = 1'b0;

    for (int ln = 0; ln < 192; ln++) begin
      int base;
      base = (ln / 12) * 32;
      if (ln == 0) begin
        vram[0] = 8'h41;
        runLine(0, 1'b1, 8'hFF, 1'b0, 6'd32, 4'd0);
      end else if (ln == 1) begin
        vram[0] = 8'h01;
        runLine(0, 1'b1, 8'h00, 1'b0, 6'd32, 4'd0);
      end else if (ln == 3) begin
        applyStimulus();
        checkOutput("a vaddr0", 32'(bus.VidAddr), 0);
        repeat (7) tick();
        checkOutput("a romdata", 32'(bus.RomData), 1);
        checkOutput("a romrow", 32'(bus.RomRow), 0);
        tick();
        checkOutput("a active", 32'(Active), 1);
        pat = 8'h08;
        for (int i = 0; i < 8; i++) begin
          checkOutput("a pixel", 32'(PixelOut), 32'(pat[7-i]));
          if (i == 4) begin
            PixClkEn = 1'b0;
            repeat (4) begin
              tick();
              checkOutput("freeze pixel", 32'(PixelOut), 1);
              checkOutput("freeze active", 32'(Active), 1);
            end
            PixClkEn = 1'b1;
          end
          tick();
        end
        repeat (74) tick();
        checkOutput("col10 vaddr", 32'(bus.VidAddr), 11);
        vram[0] = 8'h41;
        runLine(0, 1'b1, 8'hF7, 1'b0, 6'd1, 4'd0);
      end else if (ln == 4) begin
        vram[0] = 8'h81;
        runLine(0, 1'b1, 8'h00, 1'b1, 6'd32, 4'd0);
      end else if (ln == 5) begin
        vram[0] = 8'h02;
        runLine(0, 1'b1, 8'hFF, 1'b0, 6'd2, 4'd2);
      end else if (ln == 9) begin
        vram[0] = 8'h1F;
        runLine(0, 1'b1, 8'hFF, 1'b0, 6'd31, 4'd6);
      end else if (ln == 10) begin
        runLine(0, 1'b1, 8'h00, 1'b0, 6'd32, 4'd0);
      end else if (ln == 12) begin
        vram[32] = 8'h41;
        runLine(32, 1'b1, 8'hFF, 1'b0, 6'd32, 4'd0);
      end else begin
        runLine(base, 1'b0, 8'h00, 1'b0, 6'd0, 4'd0);
      end
    end

    applyStimulus();
    checkOutput("hold vaddr", 32'(bus.VidAddr), 31);
    cnt = 0;
    repeat (300) begin
      tick();
      if (Active) cnt++;
    end
    checkOutput("hold active", cnt, 0);

    vram[0] = 8'h41;
    FieldStart = 1'b1;
    LineStart = 1'b1;
    tick();
    FieldStart = 1'b0;
    LineStart = 1'b0;
    checkOutput("fs+ls vaddr", 32'(bus.VidAddr), 0);
    repeat (7) tick();
    checkOutput("fs+ls romdata", 32'(bus.RomData), 32);
    tick();
    checkOutput("fs+ls active", 32'(Active), 1);
    checkOutput("fs+ls pixel", 32'(PixelOut), 1);
    tick();
    tick();
    nReset = 1'b0;
    #1;
    checkOutput("midrst active", 32'(Active), 0);
    checkOutput("midrst pixel", 32'(PixelOut), 0);
    checkOutput("midrst romdata", 32'(bus.RomData), 0);
    checkOutput("midrst vaddr", 32'(bus.VidAddr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
